// File: rtl/fifo_uart_pkg.sv
// Shared constants and FSM state encoding for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   localparam int unsigned DefClksPerBit = 868;  // 100 MHz / 115200 baud
   localparam int unsigned DefDataW      = 8;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StPop    = 3'd1,
      StWait   = 3'd2,
      StStart  = 3'd3,
      StData   = 3'd4,
      StParity = 3'd5,
      StStop   = 3'd6
   } state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status, bundled for the UART drain stage.
interface fifo_uart_tx_if
   import fifo_uart_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_rd_en;
   logic              tx;
   logic              busy;
   logic              tx_done;

   // Transmitter side: consumes the FIFO read port and drives the serial line.
   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en,
      output tx,
      output busy,
      output tx_done
   );

   // Environment side: FIFO and whoever watches the serial line.
   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en,
      input  tx,
      input  busy,
      input  tx_done
   );
endinterface

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter with synchronous clear; tick marks the last cycle of a bit.
module uart_baud_cnt
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clr,
   output logic [$clog2(CLKS_PER_BIT)-1:0] cnt,
   output logic                            tick
);
   localparam int unsigned      CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0]  Last = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q;

   assign cnt  = cnt_q;
   assign tick = (cnt_q == Last);

   // Count 0..CLKS_PER_BIT-1, wrap on tick, hold at zero while cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a sync FIFO one byte at a time and sends each as a UART frame
// (start, DATA_W bits LSB first, optional even parity, stop).
// Define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frame).
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
   parameter int unsigned DATA_W       = DefDataW
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_uart_tx_if.master bus
);
   localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
   localparam int unsigned     BitW    = $clog2(DATA_W);
   // tx_done is registered, so it is launched one cycle before the final stop cycle.
   localparam logic [CntW-1:0] DoneCnt = CntW'(CLKS_PER_BIT - 2);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CntW-1:0]   baud_cnt;
   logic              baud_tick;
   logic              baud_clr;
   logic              rd_en_q, rd_en_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // Bit timing only runs while a frame is on the wire.
   assign baud_clr = (state_q == StIdle) || (state_q == StPop) || (state_q == StWait);

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (baud_clr),
      .cnt   (baud_cnt),
      .tick  (baud_tick)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; fifo_empty only matters in IDLE and on the final stop cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (!bus.fifo_empty) state_d = StPop;
         StPop:   state_d = StWait;
         StWait:  state_d = StStart;
         StStart: if (baud_tick) state_d = StData;
         StData: begin
            if (baud_tick && (bit_cnt_q == LastBit)) begin
`ifdef UART_TX_PARITY_EN
               state_d = StParity;
`else
               state_d = StStop;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: if (baud_tick) state_d = StStop;
`endif
         StStop:  if (baud_tick) state_d = bus.fifo_empty ? StIdle : StPop;
         default: state_d = StIdle;
      endcase
   end

   // Shift register / bit counter next state: load in WAIT, shift on each data bit boundary.
   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (state_q == StWait) begin
         shreg_d   = bus.fifo_data;
         bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
         parity_d  = ^bus.fifo_data;
`endif
      end else if ((state_q == StData) && baud_tick) begin
         shreg_d   = shreg_q >> 1;
         bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + BitW'(1);
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Output decode from the upcoming state so every output can be a flop.
   always_comb begin
      rd_en_d   = (state_d == StPop);
      busy_d    = (state_d != StIdle);
      tx_done_d = (state_q == StStop) && (baud_cnt == DoneCnt);
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // Output registers; tx idles high and snaps high on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q   <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         rd_en_q   <= rd_en_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign bus.fifo_rd_en = rd_en_q;
   assign bus.tx         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.tx_done    = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural 1-cycle-latency FIFO and a byte scoreboard.
module tb_fifo_uart_tx;
   localparam int unsigned C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FLEN = NBITS * C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_uart_tx_if #(.DATA_W(8)) bus ();

   fifo_uart_tx #(
      .CLKS_PER_BIT (C),
      .DATA_W       (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural FIFO: storage written by the stimulus, popped on rd_en with 1-cycle latency.
   logic [7:0] mem [0:63];
   int         push_cnt = 0;
   int         pop_cnt = 0;
   logic       force_empty = 1'b0;

   assign bus.fifo_empty = force_empty || (push_cnt == pop_cnt);

   always @(posedge clk) begin
      if (bus.fifo_rd_en === 1'b1) begin
         bus.fifo_data <= mem[pop_cnt % 64];
         pop_cnt       <= pop_cnt + 1;
      end
   end

   // Pop-strobe monitor over the whole run.
   int rd_cnt = 0;
   int viol_cnt = 0;
   always @(negedge clk) begin
      if (bus.fifo_rd_en === 1'b1) begin
         rd_cnt++;
         if (bus.fifo_empty !== 1'b0) viol_cnt++;
      end
   end

   logic [7:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[push_cnt % 64] = b;
      push_cnt++;
      exp_q.push_back(b);
   endtask

   // Counts high samples before tx falls; returns positioned on the first start-bit cycle.
   task automatic wait_tx_low(input string tag, output int idle);
      bit got;
      got  = 1'b0;
      idle = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.tx === 1'b0) begin
            got = 1'b1;
            break;
         end
         idle++;
      end
      chk({tag, "_start_seen"}, 64'(got), 64'd1);
   endtask

   // Samples one whole frame cycle by cycle and checks it against the scoreboard head.
   task automatic frame_check(input string tag, input bit toggle, output logic par);
      logic [43:0] otx, etx, odone, edone, obusy, ebusy;
      logic [10:0] fr;
      logic [7:0]  exp_b, dec;
      otx = '0; etx = '0; odone = '0; edone = '0; obusy = '0; ebusy = '0;
      par = 1'b0;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_has_byte"}, 64'd0, 64'd1);
         return;
      end
      exp_b   = exp_q.pop_front();
      fr      = '0;
      fr[0]   = 1'b0;
      fr[8:1] = exp_b;
`ifdef UART_TX_PARITY_EN
      fr[9]   = ^exp_b;
`endif
      fr[NBITS-1] = 1'b1;
      for (int i = 0; i < int'(FLEN); i++) begin
         if (i > 0) @(negedge clk);
         otx[i]   = bus.tx;
         odone[i] = bus.tx_done;
         obusy[i] = bus.busy;
         etx[i]   = fr[i / C];
         edone[i] = (i == int'(FLEN) - 1);
         ebusy[i] = 1'b1;
         if (toggle) force_empty = (i >= int'(2 * C) && i < int'(8 * C)) ? i[0] : 1'b0;
      end
      for (int k = 0; k < 8; k++) dec[k] = otx[(k + 1) * C + C / 2];
      par = otx[9 * C + C / 2];
      chk({tag, "_tx_wave"}, 64'(otx), 64'(etx));
      chk({tag, "_tx_done"}, 64'(odone), 64'(edone));
      chk({tag, "_busy"}, 64'(obusy), 64'(ebusy));
      chk({tag, "_byte"}, 64'(dec), 64'(exp_b));
   endtask

   initial begin
      int   idle;
      int   rd0;
      int   blen;
      logic par;

      // 1: reset state, then a long idle with an empty FIFO
      repeat (3) @(negedge clk);
      chk("rst_tx", 64'(bus.tx), 64'd1);
      chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_tx_done", 64'(bus.tx_done), 64'd0);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("idle_no_pop", 64'(rd_cnt), 64'd0);
      chk("idle_tx", 64'(bus.tx), 64'd1);

      // 2: single byte, latency and full waveform
      rd0 = rd_cnt;
      push(8'hA5);
      wait_tx_low("a5", idle);
      chk("a5_latency", 64'(idle), 64'd2);
      frame_check("a5", 1'b0, par);
      chk("a5_rd_pulses", 64'(rd_cnt - rd0), 64'd1);
      @(negedge clk);
      chk("a5_idle_after", 64'(bus.busy), 64'd0);

      // 3: seven back-to-back bytes
      rd0 = rd_cnt;
      for (int k = 0; k < 7; k++) push(8'($urandom_range(0, 255)));
      for (int k = 0; k < 7; k++) begin
         wait_tx_low("b2b", idle);
         chk("b2b_gap", 64'(idle), 64'd2);
         frame_check("b2b", 1'b0, par);
      end
      @(negedge clk);
      chk("b2b_idle_after", 64'(bus.busy), 64'd0);
      chk("b2b_rd_pulses", 64'(rd_cnt - rd0), 64'd7);
      chk("b2b_fifo_empty", 64'(bus.fifo_empty), 64'd1);

      // 4: reset during data bit 3 drops the in-flight byte
      rd0 = rd_cnt;
      push(8'h3C);
      push(8'h81);
      wait_tx_low("rst", idle);
      repeat (4 * C + 1) @(negedge clk);
      chk("rst_mid_busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", 64'(bus.tx), 64'd1);
      chk("rst_mid_busy_low", 64'(bus.busy), 64'd0);
      void'(exp_q.pop_front());  // 8'h3C is lost by design
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_tx_low("after_rst", idle);
      chk("after_rst_gap", 64'(idle), 64'd2);
      frame_check("after_rst", 1'b0, par);
      chk("rst_rd_pulses", 64'(rd_cnt - rd0), 64'd2);

      // 5: fifo_empty wiggling mid-frame must not cause extra pops
      rd0 = rd_cnt;
      push(8'h5A);
      push(8'hC3);
      wait_tx_low("wig", idle);
      frame_check("wig", 1'b1, par);
      wait_tx_low("wig2", idle);
      chk("wig2_gap", 64'(idle), 64'd2);
      frame_check("wig2", 1'b0, par);
      @(negedge clk);
      chk("wig_rd_pulses", 64'(rd_cnt - rd0), 64'd2);

      // 6: parity bytes and frame length
      push(8'h07);
      wait_tx_low("p07", idle);
      frame_check("p07", 1'b0, par);
`ifdef UART_TX_PARITY_EN
      chk("p07_parity", 64'(par), 64'd1);
`endif
      push(8'h03);
      wait_tx_low("p03", idle);
      frame_check("p03", 1'b0, par);
`ifdef UART_TX_PARITY_EN
      chk("p03_parity", 64'(par), 64'd0);
`endif
      @(negedge clk);
      push(8'h55);
      blen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) blen++;
         else if (blen > 0) break;
      end
      void'(exp_q.pop_front());
`ifdef UART_TX_PARITY_EN
      chk("busy_len", 64'(blen), 64'd46);
`else
      chk("busy_len", 64'(blen), 64'd42);
`endif

      chk("no_rd_while_empty", 64'(viol_cnt), 64'd0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
